// File: rtl/fa_pkg.sv
// fa_pkg: shared opcodes, FSM encodings and error codes for the command sequencer
package fa_pkg;
  localparam int CMD_BURST_LEN = 3;
  localparam logic [2:0] OP_IDLE = 3'd0;
  localparam logic [2:0] OP_CONV = 3'd1;
  localparam logic [2:0] OP_MAXPOOL = 3'd4;
  localparam logic [2:0] OP_AVGPOOL = 3'd5;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OP = 2'd1;
  localparam logic [1:0] ERR_STRIDE = 2'd2;
  localparam logic [1:0] ERR_STRIDE2 = 2'd3;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_CHECK  = 3'd2,
    S_ISSUE  = 3'd3,
    S_RUN    = 3'd4,
    S_FINISH = 3'd5,
    S_ERROR  = 3'd6
  } state_t;
endpackage

// File: rtl/cmd_check.sv
// cmd_check: combinational descriptor legality check; the lowest failing code wins
module cmd_check
  import fa_pkg::*;
(
  input  logic [2:0]  i_op_type,
  input  logic [3:0]  i_stride,
  input  logic [7:0]  i_kernel,
  input  logic [15:0] i_stride2,
  output logic [1:0]  o_err_code
);
  logic w_bad_op, w_bad_stride, w_bad_s2;
  assign w_bad_op = !(i_op_type inside {OP_CONV, OP_MAXPOOL, OP_AVGPOOL});
  assign w_bad_stride = i_stride == 4'd0 || {4'd0, i_stride} > i_kernel;
  assign w_bad_s2 = i_op_type == OP_CONV && i_stride2 != 16'(i_kernel) * 16'(i_stride);
  assign o_err_code = w_bad_op ? ERR_OP : w_bad_stride ? ERR_STRIDE : w_bad_s2 ? ERR_STRIDE2 : ERR_NONE;
endmodule

// File: rtl/cmd_seq.sv
// cmd_seq: fetches command bursts from the host FIFO, checks them and
// hands layer descriptors to the engine, counting completed layers.
module cmd_seq
  import fa_pkg::*;
#(
  parameter int CMD_WORDS = CMD_BURST_LEN,
  parameter int CNT_W = 7,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cmd_size,
  output logic             cmd_rd_en,
  input  logic             cmd_valid,
  input  logic [31:0]      cmd_data,
  output logic             desc_valid,
  input  logic             desc_ready,
  input  logic             eng_done,
  output logic [2:0]       op_type,
  output logic [3:0]       stride,
  output logic [7:0]       kernel,
  output logic [7:0]       i_side,
  output logic [7:0]       o_side,
  output logic [15:0]      i_channel,
  output logic [15:0]      o_channel,
  output logic [7:0]       kernel_size,
  output logic [15:0]      stride2,
  output logic [CNT_W-1:0] done_cmd_count,
  output logic [2:0]       state,
  output logic             irq,
  input  logic             irq_clr,
  output logic             err,
  output logic [1:0]       err_code
);
  localparam logic [3:0] WORDS = 4'(CMD_WORDS);
  localparam logic [3:0] LAST = 4'(CMD_WORDS - 1);
  state_t r_state, w_next;
  logic [3:0] r_req, r_rcv;
  logic [CNT_W-1:0] r_size, r_count, w_count_inc;
  logic [2:0] r_op_type;
  logic [3:0] r_stride;
  logic [7:0] r_kernel, r_i_side, r_o_side, r_kernel_size;
  logic [15:0] r_i_channel, r_o_channel, r_stride2;
  logic r_irq, r_err;
  logic [1:0] r_err_code, w_chk_code;
  logic w_fetch, w_rx, w_last;

  cmd_check u_check (
    .i_op_type (r_op_type),
    .i_stride  (r_stride),
    .i_kernel  (r_kernel),
    .i_stride2 (r_stride2),
    .o_err_code(w_chk_code)
  );

  // abort gates the handshakes combinationally so no word or descriptor escapes that cycle
  assign w_fetch = r_state == S_FETCH && !abort;
  assign w_rx = w_fetch && cmd_valid;
  assign w_last = w_rx && r_rcv == LAST;
  assign w_count_inc = &r_count ? r_count : r_count + CNT_W'(1);
  assign cmd_rd_en = w_fetch && r_req < WORDS;
  assign desc_valid = r_state == S_ISSUE && !abort;
  assign state = r_state;
  assign done_cmd_count = r_count;
  assign irq = r_irq;
  assign err = r_err;
  assign err_code = r_err_code;
  assign op_type = r_op_type;
  assign stride = r_stride;
  assign kernel = r_kernel;
  assign i_side = r_i_side;
  assign o_side = r_o_side;
  assign i_channel = r_i_channel;
  assign o_channel = r_o_channel;
  assign kernel_size = r_kernel_size;
  assign stride2 = r_stride2;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (abort) w_next = S_IDLE;
    else
      case (r_state)
        S_IDLE:           if (start) w_next = cmd_size == '0 ? S_FINISH : S_FETCH;
        S_FETCH:          if (w_last) w_next = CHECK_EN ? S_CHECK : S_ISSUE;
        S_CHECK:          w_next = w_chk_code != ERR_NONE ? S_ERROR : S_ISSUE;
        S_ISSUE:          if (desc_ready) w_next = S_RUN;
        S_RUN:            if (eng_done) w_next = w_count_inc == r_size ? S_FINISH : S_FETCH;
        S_FINISH, S_ERROR: if (irq_clr) w_next = S_IDLE;
        default:          w_next = S_IDLE;
      endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_req <= '0;
      r_rcv <= '0;
      {r_op_type, r_stride, r_kernel, r_i_side, r_o_side} <= '0;
      {r_i_channel, r_o_channel, r_kernel_size, r_stride2} <= '0;
    end else begin
      r_req <= w_fetch ? r_req + 4'(cmd_rd_en) : '0;
      r_rcv <= w_fetch ? r_rcv + 4'(cmd_valid) : '0;
      if (w_rx && r_rcv == 4'd0) begin
        r_op_type <= cmd_data[2:0];
        r_stride <= cmd_data[7:4];
        {r_o_side, r_i_side, r_kernel} <= cmd_data[31:8];
      end
      if (w_rx && r_rcv == 4'd1) {r_o_channel, r_i_channel} <= cmd_data;
      if (w_rx && r_rcv == 4'd2) begin
        r_kernel_size <= cmd_data[15:8];
        r_stride2 <= cmd_data[31:16];
      end
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_size <= '0;
      r_count <= '0;
    end else if (start && r_state == S_IDLE && !abort) begin
      r_size <= cmd_size;
      r_count <= '0;
    end else if (eng_done && r_state == S_RUN && !abort) r_count <= w_count_inc;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_irq <= 1'b0;
      r_err <= 1'b0;
      r_err_code <= ERR_NONE;
    end else if (irq_clr) begin
      r_irq <= 1'b0;
      r_err <= 1'b0;
      r_err_code <= ERR_NONE;
    end else if (!abort) begin
      if (r_state == S_FINISH || r_state == S_ERROR) r_irq <= 1'b1;
      if (r_state == S_ERROR) r_err <= 1'b1;
      if (r_state == S_CHECK && w_chk_code != ERR_NONE) r_err_code <= w_chk_code;
    end
endmodule

// File: tb/tb_cmd_seq.sv
// tb_cmd_seq: directed bench with a descriptor scoreboard built from the raw command words
module tb_cmd_seq;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_CHECK = 3'd2, ST_ISSUE = 3'd3, ST_RUN = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5, ST_ERROR = 3'd6;

  typedef struct packed {
    logic [2:0] op; logic [3:0] st; logic [7:0] k, isd, osd;
    logic [15:0] ic, oc; logic [7:0] ks; logic [15:0] s2;
  } desc_t;

  logic clk = 0, rst = 0, start = 0, abort = 0, cmd_rd_en, cmd_valid = 0;
  logic [6:0] cmd_size = 0, done_cmd_count;
  logic [31:0] cmd_data = 0;
  logic desc_valid, desc_ready = 0, eng_done = 0, irq, irq_clr = 0, err;
  logic [2:0] op_type, state;
  logic [3:0] stride;
  logic [7:0] kernel, i_side, o_side, kernel_size;
  logic [15:0] i_channel, o_channel, stride2;
  logic [1:0] err_code;

  int n_checks = 0, n_errors = 0, rd_cnt = 0, dv_cnt = 0, pend = 0, cyc = 0;
  bit gap = 0;
  logic [31:0] fifo_q[$];
  desc_t exp_q[$];

  cmd_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cmd_size(cmd_size),
    .cmd_rd_en(cmd_rd_en), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .eng_done(eng_done),
    .op_type(op_type), .stride(stride), .kernel(kernel), .i_side(i_side), .o_side(o_side),
    .i_channel(i_channel), .o_channel(o_channel), .kernel_size(kernel_size), .stride2(stride2),
    .done_cmd_count(done_cmd_count), .state(state), .irq(irq), .irq_clr(irq_clr),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic desc_t decode(input logic [31:0] w0, w1, w2);
    decode = '{w0[2:0], w0[7:4], w0[15:8], w0[23:16], w0[31:24], w1[15:0], w1[31:16], w2[15:8], w2[31:16]};
  endfunction

  function automatic logic [1:0] exp_code(input logic [31:0] w0, w2);
    int op = int'(w0[2:0]);
    int s = int'(w0[7:4]);
    int k = int'(w0[15:8]);
    if (op != 1 && op != 4 && op != 5) return 2'd1;
    if (s == 0 || s > k) return 2'd2;
    if (op == 1 && int'(w2[31:16]) != (k * s) % 65536) return 2'd3;
    return 2'd0;
  endfunction

  function automatic desc_t cur_desc();
    cur_desc = '{op_type, stride, kernel, i_side, o_side, i_channel, o_channel, kernel_size, stride2};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] w0, w1, w2);
    fifo_q.push_back(w0);
    fifo_q.push_back(w1);
    fifo_q.push_back(w2);
    if (exp_code(w0, w2) == 2'd0) exp_q.push_back(decode(w0, w1, w2));
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    int n = 0;
    while (state !== s && n < 100) begin tick(); n++; end
    chk(nm, state, s);
  endtask

  task automatic pulse_start(input logic [6:0] sz);
    cmd_size = sz; start = 1; tick(); start = 0;
  endtask

  task automatic pulse_done();
    eng_done = 1; tick(); eng_done = 0;
  endtask

  task automatic clear_irq();
    irq_clr = 1; tick(); irq_clr = 0;
    chk("clr_state", state, ST_IDLE);
    chk("clr_irq", irq, 1'b0);
    chk("clr_err", {err, err_code}, 3'b0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_state"}, state, ST_IDLE);
    chk({nm, "_ctl"}, {cmd_rd_en, desc_valid, irq, err, err_code}, 6'b0);
    chk({nm, "_cnt"}, done_cmd_count, 7'd0);
    chk({nm, "_fields"}, cur_desc(), 87'd0);
  endtask

  task automatic run_err(input logic [31:0] w0, w2, input logic [1:0] code, input string nm);
    load(w0, 32'h0010_0008, w2);
    dv_cnt = 0;
    pulse_start(7'd1);
    wait_state(ST_ERROR, {nm, "_state"});
    chk({nm, "_code"}, err_code, code);
    chk({nm, "_irq_early"}, irq, 1'b0);
    tick();
    chk({nm, "_irq"}, {irq, err}, 2'b11);
    chk({nm, "_no_desc"}, dv_cnt, 0);
    clear_irq();
  endtask

  // host FIFO: each request is answered no earlier than the following cycle
  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (rst) begin
        pend = 0;
        cmd_valid = 0;
      end else begin
        if (pend > 0 && (!gap || cyc % 3 == 0)) begin
          cmd_valid = 1;
          cmd_data = fifo_q.size() != 0 ? fifo_q.pop_front() : 32'h0;
          pend--;
        end else begin
          cmd_valid = 0;
          cmd_data = 32'hDEAD_BEEF;
        end
        if (cmd_rd_en) pend++;
      end
    end
  end

  // scoreboard: every accepted descriptor matches the next expected one; held descriptors stay stable
  initial begin
    desc_t prev;
    desc_t e;
    bit prev_v = 0;
    forever begin
      @(negedge clk);
      if (rst) prev_v = 0;
      else begin
        if (cmd_rd_en) rd_cnt++;
        if (desc_valid) dv_cnt++;
        if (desc_valid && prev_v) chk("desc_stable", cur_desc(), prev);
        if (desc_valid && desc_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_desc: got %0h expected none", cur_desc());
          end else begin
            e = exp_q.pop_front();
            chk("desc_fields", cur_desc(), e);
          end
        end
        if (err) chk("err_implies_irq", irq, 1'b1);
        prev_v = desc_valid && !desc_ready;
        prev = cur_desc();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst = 1;
    @(negedge clk);
    chk_reset("reset");
    tick();
    rst = 0;
    tick();

    // reset in the middle of a fetch, after the first word has landed
    load(32'h1A1A_0311, 32'h0040_0010, 32'h0003_0900);
    pulse_start(7'd1);
    n = 0;
    while (!cmd_valid && n < 20) begin tick(); n++; end
    tick();
    rst = 1;
    @(negedge clk);
    chk_reset("midfetch_rst");
    fifo_q.delete();
    exp_q.delete();
    tick();
    rst = 0;
    rd_cnt = 0;
    repeat (4) tick();
    chk("post_rst_no_reads", rd_cnt, 0);
    chk("post_rst_state", state, ST_IDLE);

    // two-layer conv run with desc_ready tied high
    desc_ready = 1;
    rd_cnt = 0;
    load(32'h1A1A_0311, 32'h0040_0010, 32'h0003_0900);
    load(32'h1A1A_0311, 32'h0040_0010, 32'h0003_0900);
    pulse_start(7'd2);
    wait_state(ST_CHECK, "run2_check");
    tick();
    chk("run2_dv_after_check", desc_valid, 1'b1);
    wait_state(ST_RUN, "run2_run1");
    pulse_done();
    chk("run2_count1", done_cmd_count, 7'd1);
    wait_state(ST_RUN, "run2_run2");
    pulse_done();
    chk("run2_finish", state, ST_FINISH);
    chk("run2_irq_early", irq, 1'b0);
    tick();
    chk("run2_irq", irq, 1'b1);
    chk("run2_err", err, 1'b0);
    chk("run2_count", done_cmd_count, 7'd2);
    chk("run2_reads", rd_cnt, 6);
    chk("run2_all_issued", exp_q.size(), 0);
    chk("run2_geom", {stride, kernel, i_side, o_side}, {4'd1, 8'd3, 8'd26, 8'd26});
    chk("run2_chan", {i_channel, o_channel}, {16'd16, 16'd64});
    clear_irq();
    desc_ready = 0;

    // illegal descriptors; the lowest failing code is reported
    run_err(32'h1A1A_0312, 32'h0003_0900, 2'd1, "op2");
    run_err(32'h1A1A_0341, 32'h000C_0900, 2'd2, "stride_gt_k");
    run_err(32'h1A1A_0311, 32'h0004_0900, 2'd3, "stride2");
    run_err(32'h0505_0304, 32'h0000_0000, 2'd2, "stride0");
    run_err(32'h0505_0300, 32'h0000_0000, 2'd1, "op0_stride0");

    // gapped FIFO delivery and a slow engine handshake (maxpool, stride == kernel)
    gap = 1;
    rd_cnt = 0;
    load(32'h0C0A_0224, 32'h0020_0008, 32'h1234_5600);
    pulse_start(7'd1);
    wait_state(ST_ISSUE, "gap_issue");
    repeat (5) begin
      chk("gap_dv_held", desc_valid, 1'b1);
      tick();
    end
    desc_ready = 1;
    tick();
    desc_ready = 0;
    chk("gap_run", state, ST_RUN);
    chk("gap_reads", rd_cnt, 3);
    chk("gap_fields", {op_type, stride, kernel, kernel_size, stride2}, {3'd4, 4'd2, 8'd2, 8'h56, 16'h1234});
    pulse_done();
    chk("gap_finish", state, ST_FINISH);
    tick();
    chk("gap_irq", irq, 1'b1);
    clear_irq();
    gap = 0;

    // abort in RUN coincident with eng_done
    desc_ready = 1;
    load(32'h1A1A_0311, 32'h0040_0010, 32'h0003_0900);
    load(32'h0808_0425, 32'h0001_0002, 32'h0000_0100);
    pulse_start(7'd2);
    wait_state(ST_RUN, "abort_run1");
    pulse_done();
    wait_state(ST_RUN, "abort_run2");
    abort = 1; eng_done = 1;
    tick();
    abort = 0; eng_done = 0;
    chk("abort_state", state, ST_IDLE);
    chk("abort_count", done_cmd_count, 7'd1);
    chk("abort_irq", irq, 1'b0);
    desc_ready = 0;
    rd_cnt = 0;
    tick();
    chk("abort_idle_no_reads", {state, rd_cnt[3:0]}, {ST_IDLE, 4'd0});

    // empty run: straight to FINISH with no FIFO reads; clear beats a coincident start
    pulse_start(7'd0);
    chk("empty_finish", state, ST_FINISH);
    tick();
    chk("empty_irq", irq, 1'b1);
    pulse_done();
    chk("empty_count", done_cmd_count, 7'd0);
    irq_clr = 1; start = 1; cmd_size = 7'd3;
    tick();
    irq_clr = 0; start = 0;
    chk("clr_start_state", state, ST_IDLE);
    tick();
    chk("clr_start_stays_idle", state, ST_IDLE);
    chk("clr_start_irq", irq, 1'b0);
    chk("empty_reads", rd_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cmd_seq.md
# cmd_seq

Parametrised command sequencer between the host command FIFO (read side, `clk` domain) and the convolution/pooling engine. It fetches fixed-length command bursts and unpacks them into layer descriptor fields. Each descriptor is checked for legality and presented to the engine through a valid/ready handshake. The block counts completed layers and raises a clearable interrupt when the programmed layer count is reached or a malformed command is detected.

## Interface
- `CMD_WORDS`, 3: 32-bit words per command (3..15); words beyond index 2 are read and discarded.
- `CNT_W`, 7: width of layer counters.
- `CHECK_EN`, 1: enable descriptor legality checks.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a run from IDLE, ignored elsewhere.
- `abort`  in  1  synchronous; returns to IDLE from any state.
- `cmd_size`  in  CNT_W  number of layers in the run; sampled on `start`.
- `cmd_rd_en`  out  1  FIFO read request.
- `cmd_valid`  in  1  `cmd_data` valid (one cycle after the matching `cmd_rd_en`).
- `cmd_data`  in  32  command word.
- `desc_valid`  out  1  descriptor presented to engine.
- `desc_ready`  in  1  engine accepts descriptor.
- `eng_done`  in  1  one-cycle pulse; current layer finished.
- `op_type` 3, `stride` 4, `kernel` 8, `i_side` 8, `o_side` 8, `i_channel` 16, `o_channel` 16, `kernel_size` 8, `stride2` 16  out  decoded fields, held stable from FETCH completion until the next FETCH captures.
- `done_cmd_count`  out  CNT_W  layers completed in this run.
- `state`  out  3  current FSM state.
- `irq`  out  1  run finished or error; sticky.
- `irq_clr`  in  1  clears `irq`/`err`; FINISH/ERROR go to IDLE.
- `err`  out  1  error flag.
- `err_code`  out  2  0 none, 1 illegal op_type, 2 stride/kernel, 3 stride2 mismatch.

## Operation
- Word 0: op_type[2:0], stride[7:4], kernel[15:8], i_side[23:16], o_side[31:24].
- Word 1: i_channel[15:0], o_channel[31:16].
- Word 2: kernel_size[15:8], stride2[31:16].
- States: IDLE=0, FETCH=1, CHECK=2, ISSUE=3, RUN=4, FINISH=5, ERROR=6.
- IDLE: on `start`, latch `cmd_size` and clear `done_cmd_count`. If `cmd_size`==0, go to FINISH; otherwise go to FETCH.
- FETCH:
  - Request counter `req` drives `cmd_rd_en`=1 while `req`<CMD_WORDS; each asserted cycle increments `req`.
  - Receive counter `rcv` increments on `cmd_valid` and steers `cmd_data` to fields by index.
  - `cmd_valid` outside FETCH is ignored.
  - When `rcv` reaches CMD_WORDS, go to CHECK.
- CHECK (1 cycle), only when CHECK_EN=1:
  - op_type ∉ {1,4,5} → err_code 1.
  - stride==0 or stride>kernel → err_code 2.
  - op_type==1 and stride2≠kernel×stride (16-bit product) → err_code 3.
  - Lowest code wins. Any failure → ERROR; otherwise → ISSUE.
  - CHECK_EN=0: always → ISSUE.
- ISSUE: `desc_valid`=1 until `desc_ready`; on handshake go to RUN.
- RUN: on `eng_done`, increment `done_cmd_count`. If the new count == latched `cmd_size`, go to FINISH; otherwise go to FETCH (req/rcv cleared).
- FINISH / ERROR: `irq`=1 (ERROR also sets `err`), held until `irq_clr`, then IDLE.
- `eng_done` outside RUN is ignored. `desc_ready` outside ISSUE is ignored.
- `abort` has priority over every other transition. It forces IDLE, clears req/rcv/`desc_valid`/`cmd_rd_en`, and leaves `irq`/`err`/count untouched.

## Timing
- Reset: all outputs 0; state IDLE; counters 0.
- `start`→FETCH and first `cmd_rd_en` on the next cycle.
- FETCH lasts ≥ CMD_WORDS+1 cycles with back-to-back `cmd_valid`. The FIFO may delay or drop `cmd_valid`; the block stalls without timeout.
- CHECK is 1 cycle (0 cycles when CHECK_EN=0: FETCH→ISSUE directly).
- `desc_valid` rises the cycle after CHECK; the handshake completes in the cycle where both are high.
- `irq` rises the cycle after entering FINISH/ERROR. `irq_clr` and `start` in the same cycle in FINISH: clear wins, `start` ignored.
- `eng_done` coincident with `abort`: `abort` wins, count not incremented.
- `done_cmd_count` saturates at 2^CNT_W−1.

## Structure
- Shared package `fa_pkg`:
  - op_type constants (OP_IDLE=0, OP_CONV=1, OP_MAXPOOL=4, OP_AVGPOOL=5).
  - state encodings.
  - err_code constants.
  - CMD_BURST_LEN default.
- One sub-module `cmd_check`: combinational legality checker (fields in, err_code out), reusable by the host-side model.

## Test plan
- Reset mid-FETCH (after 1 word) → all outputs 0, state 0, no `cmd_rd_en` until `start`.
- `cmd_size`=2, words {0x1A1A0311, 0x00400010, 0x00030900}, `desc_ready` tied 1, `eng_done` ×2 → two descriptors issued with stride=1, kernel=3, i_side=26, o_side=26, i_channel=16, o_channel=64; `irq`=1, `done_cmd_count`=2, `err`=0.
- op_type=2 → ERROR, `err_code`=1, `irq`=1, no `desc_valid`; `irq_clr` → IDLE, `irq`=0.
- stride=4, kernel=3 → `err_code`=2. Conv with stride2=4, kernel=3, stride=1 → `err_code`=3.
- `cmd_valid` gapped (1 of 3 cycles), `desc_ready` delayed 5 cycles → fields correct, `desc_valid` held stable until accepted.
- `abort` during RUN with `eng_done` in the same cycle → IDLE, count unchanged. `cmd_size`=0 → FINISH with no FIFO reads.
